widen_rr_arbiter: RTL and testbench
===================================

// Module: widen_rr_arbiter
// PURPOSE
//  Shares one WIDTH_IN->WIDTH_OUT widening path among NUM_REQ requesters.
//  Round-robin arbitration picks one request per accepted beat; data is
//  extended to WIDTH_OUT and held in a single output register with
//  valid/ready handshake. Sits between requester streams and the widened sink.
// PARAMETERS
//  NUM_REQ   4  number of requesters, >=2
//  WIDTH_IN  4  requester data width, >=1
//  WIDTH_OUT 8  output data width, >=WIDTH_IN (equal = plain pass-through)
//  SRC_W     $clog2(NUM_REQ)  localparam, width of out_src
// PORTS
//  clk        in   1                 single clock, rising edge
//  rst        in   1                 synchronous, active-high reset
//  req_valid  in   NUM_REQ           bit i = requester i has a beat
//  req_data   in   NUM_REQ*WIDTH_IN  requester i at [i*WIDTH_IN +: WIDTH_IN]
//  req_ready  out  NUM_REQ           one-hot or zero; beat i taken this cycle
//  out_valid  out  1                 output register holds a beat
//  out_data   out  WIDTH_OUT         extended data of held beat
//  out_src    out  SRC_W             index of requester that sourced the beat
//  out_ready  in   1                 sink accepts held beat
// BEHAVIOUR
//  - Reset (rst=1 at posedge): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//    A held beat is discarded; rst overrides all other activity.
//  - req_ready combinational: load = !out_valid || out_ready;
//    req_ready[i] = load && grant[i]; req_ready=0 while rst=1.
//  - grant: first i with req_valid[i]=1 scanning rr_ptr, rr_ptr+1, ...
//    mod NUM_REQ; zero if no req_valid.
//  - On posedge with load=1 and a grant to k: out_valid<=1,
//    out_data<=ext(req_data[k]), out_src<=k, rr_ptr<=(k+1) mod NUM_REQ.
//  - load=1, no grant: out_valid<=0; out_data/out_src/rr_ptr hold.
//  - load=0 (out_valid=1, out_ready=0): all registers hold, req_ready=0;
//    out_data/out_src stable until handshake.
//  - Latency: 1 cycle req handshake -> out_valid. Throughput 1 beat/cycle
//    (simultaneous out_ready drain and new accept in same cycle).
//  - FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//    EMPTY -grant-> FULL; FULL -out_ready&grant-> FULL (new beat);
//    FULL -out_ready&!grant-> EMPTY; FULL -!out_ready-> FULL (stall).
//  - rr_ptr wraps NUM_REQ-1 -> 0. Requester dropping req_valid before its
//    req_ready loses nothing; the arbiter never captures without req_ready.
//  - Fairness: continuously requesting requester waits <= NUM_REQ-1 beats.
//  - Requester data not examined when req_valid=0 (X-tolerant).
// CONFIGURATION
//  WIDEN_RR_ARBITER_SIGN_EXT_EN
//   defined:   ext() replicates req_data MSB into upper WIDTH_OUT-WIDTH_IN bits.
//   undefined: ext() zero-fills upper bits (default).
//   WIDTH_OUT==WIDTH_IN: identical either way.
// TESTING (NUM_REQ=4, WIDTH_IN=4, WIDTH_OUT=8)
//  1 rst 2 cycles, out_ready=1 -> out_valid=0, out_data=0x00, out_src=0, req_ready=0.
//  2 req_valid=0b0100, data[2]=0x9 -> next cycle req_ready=0b0100 taken, then
//    out_valid=1, out_data=0x09 (0xF9 with SIGN_EXT_EN), out_src=2.
//  3 req_valid=0b1111 held, out_ready=1 -> grants 0,1,2,3,0 on successive
//    cycles; out_src sequence 0,1,2,3,0, one beat per cycle.
//  4 out_ready=0 while FULL, req_valid=0b0011 -> req_ready=0, out_data/out_src
//    stable 5 cycles; out_ready=1 -> held beat drains, next grant same cycle.
//  5 after grant to 3, req_valid=0b1001 -> rr_ptr wrapped to 0, requester 0 wins.
//  6 rst asserted while FULL and out_ready=0 -> next cycle out_valid=0,
//    rr_ptr=0; held beat never handshakes.

Source files
------------

// File: rtl/widen_rr_arbiter.sv
// Round-robin arbiter feeding one widening output register with valid/ready handshake.
// WIDEN_RR_ARBITER_SIGN_EXT_EN selects sign extension; zero-fill when undefined.

module widen_rr_lane #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8
) (
  input  logic [WIDTH_IN-1:0]  d,
  output logic [WIDTH_OUT-1:0] d_ext
);
  if (WIDTH_OUT == WIDTH_IN) begin : g_pass
    assign d_ext = d;
  end else begin : g_ext
`ifdef WIDEN_RR_ARBITER_SIGN_EXT_EN
    assign d_ext = {{(WIDTH_OUT-WIDTH_IN){d[WIDTH_IN-1]}}, d};
`else
    assign d_ext = {{(WIDTH_OUT-WIDTH_IN){1'b0}}, d};
`endif
  end
endmodule

module widen_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 8,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WIDTH_IN-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [WIDTH_OUT-1:0]        out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t                             state_q, state_d;
  logic [SRC_W-1:0]                   rr_ptr;
  logic [SRC_W-1:0]                   gnt_idx;
  logic                               has_gnt;
  logic                               load;
  logic [NUM_REQ-1:0][WIDTH_OUT-1:0]  ext_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    widen_rr_lane #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_lane (
      .d     (req_data[i*WIDTH_IN +: WIDTH_IN]),
      .d_ext (ext_data[i])
    );
  end

  // Scan from rr_ptr upward with explicit wrap so non-power-of-2 NUM_REQ works.
  always_comb begin
    int idx;
    has_gnt = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!has_gnt && req_valid[idx]) begin
        has_gnt = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign load      = !out_valid || out_ready;
  assign req_ready = (load && has_gnt && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d = state_q;
    if (load) state_d = has_gnt ? FULL : EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (load && has_gnt) begin
        out_data <= ext_data[gnt_idx];
        out_src  <= gnt_idx;
        rr_ptr   <= (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_widen_rr_arbiter.sv
// Directed bench for widen_rr_arbiter (NUM_REQ=4, WIDTH_IN=4, WIDTH_OUT=8).
module tb_widen_rr_arbiter;
  localparam int NUM_REQ = 4, WIDTH_IN = 4, WIDTH_OUT = 8, SRC_W = 2;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*WIDTH_IN-1:0] req_data = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        out_valid;
  logic [WIDTH_OUT-1:0]        out_data;
  logic [SRC_W-1:0]            out_src;
  logic                        out_ready = 1'b1;

  int n_chk = 0;
  int n_bad = 0;
  logic [3:0] dat [4];

  widen_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ext4(input logic [3:0] d);
`ifdef WIDEN_RR_ARBITER_SIGN_EXT_EN
    return {{4{d[3]}}, d};
`else
    return {4'h0, d};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = dat[i];
  endtask

  initial begin
    // reset: outputs clear, ready suppressed even with requests pending
    rst = 1'b1; out_ready = 1'b1; req_valid = 4'b1111;
    dat = '{4'h3, 4'hA, 4'h9, 4'hC}; set_data();
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'h00);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // single request from 2
    rst = 1'b0; req_valid = 4'b0100; #1;
    chk("t2_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  32'(out_data),  32'(ext4(4'h9)));
    chk("t2_src",   32'(out_src),   32'd2);
    #1;
    tick();
    chk("t2_drain", 32'(out_valid), 32'd0);
    chk("t2_hold",  32'(out_src),   32'd2);

    // rotation 0,1,2,3,0 from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    dat = '{4'h3, 4'hA, 4'h5, 4'hC}; set_data();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("t3_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
      tick();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_src",   32'(out_src),   32'(n % 4));
      chk("t3_data",  32'(out_data),  32'(ext4(dat[n % 4])));
    end

    // stall: holding beat from 0, ptr at 1
    out_ready = 1'b0; req_valid = 4'b0011; #1;
    for (int n = 0; n < 5; n++) begin
      chk("t4_ready", 32'(req_ready), 32'd0);
      tick();
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_src",   32'(out_src),   32'd0);
      chk("t4_data",  32'(out_data),  32'(ext4(4'h3)));
      #1;
    end
    out_ready = 1'b1; #1;
    chk("t4_rel_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("t4_rel_src",  32'(out_src),  32'd1);
    chk("t4_rel_data", 32'(out_data), 32'(ext4(4'hA)));

    // wrap: grant 3, then 0 wins over 3
    req_valid = 4'b1000; #1;
    chk("t5_g3", 32'(req_ready), 32'b1000);
    tick();
    chk("t5_src3", 32'(out_src), 32'd3);
    req_valid = 4'b1001; #1;
    chk("t5_wrap", 32'(req_ready), 32'b0001);
    tick();
    chk("t5_src0", 32'(out_src), 32'd0);
    #1;
    chk("t5_next", 32'(req_ready), 32'b1000);
    tick();
    chk("t5_src3b", 32'(out_src), 32'd3);

    // reset while FULL and stalled
    out_ready = 1'b0; req_valid = 4'b0110; #1;
    chk("t6_stall", 32'(req_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1; #1;
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_src",   32'(out_src),   32'd0);
    chk("t6_data",  32'(out_data),  32'd0);
    req_valid = 4'b1111; #1;
    chk("t6_ptr", 32'(req_ready), 32'b0001);
    tick();
    chk("t6_src0", 32'(out_src), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
